// File: rtl/reflex_round_ctrl.sv
// reflex_round_ctrl
//   Round sequencer for the reflex trainer: IDLE -> COUNTDOWN -> PLAY -> OVER.
//   During PLAY it paces ball spawns, scores hits and counts timed-out balls.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active low
//   start_btn     start request level; acted on at its rising edge
//   hit           cursor-on-ball-with-click level; acted on at its rising edge
//   ball_req      one-cycle request for a new ball position
//   ball_visible  ball is to be drawn
//   playing       high in PLAY
//   game_over     high in OVER
//   state         IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3
//   seconds_left  countdown / round seconds remaining
//   score         hits, saturating at 99
//   misses        timed-out balls, saturating at 99
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | after reset, all outputs low, waiting for a start edge
// S_COUNT   | pre-round countdown, seconds_left counts COUNT_SEC down
// S_PLAY    | round running, balls spawned, hits and misses counted
// S_OVER    | round finished, score/misses held until next start edge
module reflex_round_ctrl #(
  parameter int TICK_CYCLES  = 100000,
  parameter int SEC_TICKS    = 1000,
  parameter int COUNT_SEC    = 3,
  parameter int ROUND_SEC    = 30,
  parameter int BALL_TIMEOUT = 1500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       hit,
  output logic       ball_req,
  output logic       ball_visible,
  output logic       playing,
  output logic       game_over,
  output logic [1:0] state,
  output logic [4:0] seconds_left,
  output logic [6:0] score,
  output logic [6:0] misses
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
  localparam int BW = $clog2(BALL_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] SEC_LAST   = SW'(SEC_TICKS - 1);
  localparam logic [BW-1:0] BALL_LAST  = BW'(BALL_TIMEOUT - 1);
  localparam logic [4:0]    COUNT_INIT = 5'(COUNT_SEC);
  localparam logic [4:0]    ROUND_INIT = 5'(ROUND_SEC);
  localparam logic [6:0]    SAT        = 7'd99;

  logic [1:0]    state_q, state_d;
  logic          start_d_q, hit_d_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [BW-1:0] ball_tmr_q, ball_tmr_d;
  logic [4:0]    sec_left_q, sec_left_d;
  logic [6:0]    score_q, score_d;
  logic [6:0]    misses_q, misses_d;
  logic          ball_req_q, ball_req_d;
  logic          ball_vis_q, ball_vis_d;
  logic          playing_q, playing_d;
  logic          game_over_q, game_over_d;

  logic start_e, hit_e, tick, sec, last_sec, timeout, hit_ok;

  assign start_e  = start_btn & ~start_d_q;
  assign hit_e    = hit & ~hit_d_q;
  assign tick     = (tick_cnt_q == TICK_LAST);
  assign sec      = tick & (sec_cnt_q == SEC_LAST);
  assign last_sec = sec & (sec_left_q == 5'd1);
  assign timeout  = tick & (ball_tmr_q == BALL_LAST);
  // An edge while ball_req is high was aimed at the ball being replaced.
  assign hit_ok   = hit_e & ~ball_req_q;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    ball_tmr_d  = ball_tmr_q;
    sec_left_d  = sec_left_q;
    score_d     = score_q;
    misses_d    = misses_q;
    ball_req_d  = 1'b0;
    ball_vis_d  = ball_vis_q;
    playing_d   = playing_q;
    game_over_d = game_over_q;

    // Prescaler only runs in the timed phases; every state entry restarts it.
    if (state_q == S_COUNT || state_q == S_PLAY) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      if (tick) begin
        sec_cnt_d = sec ? '0 : sec_cnt_q + SW'(1);
      end
    end

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_e) begin
          state_d     = S_COUNT;
          sec_left_d  = COUNT_INIT;
          score_d     = '0;
          misses_d    = '0;
          ball_vis_d  = 1'b0;
          playing_d   = 1'b0;
          game_over_d = 1'b0;
          tick_cnt_d  = '0;
          sec_cnt_d   = '0;
        end
      end

      S_COUNT: begin
        if (last_sec) begin
          state_d    = S_PLAY;
          sec_left_d = ROUND_INIT;
          ball_vis_d = 1'b1;
          playing_d  = 1'b1;
          ball_req_d = 1'b1;
          ball_tmr_d = '0;
          tick_cnt_d = '0;
          sec_cnt_d  = '0;
        end else if (sec) begin
          sec_left_d = sec_left_q - 5'd1;
        end
      end

      S_PLAY: begin
        if (tick) begin
          ball_tmr_d = ball_tmr_q + BW'(1);
        end
        // A hit landing on the timeout cycle wins; the ball was caught.
        if (hit_ok) begin
          score_d = (score_q == SAT) ? SAT : score_q + 7'd1;
        end else if (timeout) begin
          misses_d = (misses_q == SAT) ? SAT : misses_q + 7'd1;
        end
        if (hit_ok || timeout) begin
          ball_tmr_d = '0;
          // No new ball when the round is ending this cycle.
          ball_req_d = ~last_sec;
        end
        if (last_sec) begin
          state_d     = S_OVER;
          sec_left_d  = '0;
          ball_vis_d  = 1'b0;
          playing_d   = 1'b0;
          game_over_d = 1'b1;
          tick_cnt_d  = '0;
          sec_cnt_d   = '0;
        end else if (sec) begin
          sec_left_d = sec_left_q - 5'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      start_d_q   <= 1'b0;
      hit_d_q     <= 1'b0;
      tick_cnt_q  <= '0;
      sec_cnt_q   <= '0;
      ball_tmr_q  <= '0;
      sec_left_q  <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      ball_req_q  <= 1'b0;
      ball_vis_q  <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_d_q   <= start_btn;
      hit_d_q     <= hit;
      tick_cnt_q  <= tick_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      ball_tmr_q  <= ball_tmr_d;
      sec_left_q  <= sec_left_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      ball_req_q  <= ball_req_d;
      ball_vis_q  <= ball_vis_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  assign state        = state_q;
  assign seconds_left = sec_left_q;
  assign score        = score_q;
  assign misses       = misses_q;
  assign ball_req     = ball_req_q;
  assign ball_visible = ball_vis_q;
  assign playing      = playing_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// tb_reflex_round_ctrl
//   Directed round sequence plus a randomized stretch, every cycle compared
//   against a timeline model: phases are described by their start cycle, and
//   seconds, ticks and ball timeouts are derived arithmetically from the
//   elapsed cycle count within the phase.
module tb_reflex_round_ctrl;

  localparam int T      = 4;
  localparam int S      = 10;
  localparam int CS     = 3;
  localparam int RS     = 5;
  localparam int BT     = 15;
  localparam int TS     = T * S;
  localparam int CD_LEN = CS * TS;
  localparam int PL_LEN = RS * TS;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       hit;
  logic       ball_req;
  logic       ball_visible;
  logic       playing;
  logic       game_over;
  logic [1:0] state;
  logic [4:0] seconds_left;
  logic [6:0] score;
  logic [6:0] misses;

  int checks = 0;
  int errors = 0;

  // Timeline model
  int cyc;       // cycle index since last reset release
  int m_state;   // 0 idle, 1 countdown, 2 play, 3 over
  int m_ps;      // first cycle of the current phase
  int m_score;
  int m_miss;
  int m_req;     // cycle in which a ball request is due
  int m_clr;     // cycle in which the current ball's timer was last cleared
  bit m_prev_s;
  bit m_prev_h;
  int req_seen;

  reflex_round_ctrl #(
    .TICK_CYCLES (T),
    .SEC_TICKS   (S),
    .COUNT_SEC   (CS),
    .ROUND_SEC   (RS),
    .BALL_TIMEOUT(BT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .hit         (hit),
    .ball_req    (ball_req),
    .ball_visible(ball_visible),
    .playing     (playing),
    .game_over   (game_over),
    .state       (state),
    .seconds_left(seconds_left),
    .score       (score),
    .misses      (misses)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_sl();
    int e;
    e = cyc - m_ps;
    case (m_state)
      1:       return CS - e / TS;
      2:       return RS - e / TS;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    cyc      = 0;
    m_state  = 0;
    m_ps     = 0;
    m_score  = 0;
    m_miss   = 0;
    m_req    = -1;
    m_clr    = -1;
    m_prev_s = 1'b0;
    m_prev_h = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    start_btn = 1'b0;
    hit       = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk(tag, {ball_req, ball_visible, playing, game_over, state, seconds_left, score, misses}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: compare outputs of the current cycle, advance the model
  // with this cycle's inputs, then move to just after the next rising edge.
  task automatic step(input bit s, input bit h);
    logic [24:0] exp_vec;
    logic [24:0] obs_vec;
    int  e;
    bit  req_now, s_e, h_e, tick, tmo, acc;
    start_btn = s;
    hit       = h;
    e       = cyc - m_ps;
    req_now = (m_req == cyc);
    exp_vec = {req_now, (m_state == 2), (m_state == 2), (m_state == 3), 2'(m_state),
               5'(exp_sl()), 7'(m_score), 7'(m_miss)};
    obs_vec = {ball_req, ball_visible, playing, game_over, state, seconds_left, score, misses};
    if (ball_req === 1'b1) req_seen++;
    checks++;
    assert (obs_vec === exp_vec) else begin
      errors++;
      $error("FAIL cycle_outputs cyc=%0d observed req/vis/play/over/st/sec/score/miss=%b/%b/%b/%b/%0d/%0d/%0d/%0d expected=%b/%b/%b/%b/%0d/%0d/%0d/%0d",
             cyc, obs_vec[24], obs_vec[23], obs_vec[22], obs_vec[21], obs_vec[20:19],
             obs_vec[18:14], obs_vec[13:7], obs_vec[6:0],
             exp_vec[24], exp_vec[23], exp_vec[22], exp_vec[21], exp_vec[20:19],
             exp_vec[18:14], exp_vec[13:7], exp_vec[6:0]);
    end
    s_e = s && !m_prev_s;
    h_e = h && !m_prev_h;
    case (m_state)
      0, 3: begin
        if (s_e) begin
          m_state = 1;
          m_ps    = cyc + 1;
          m_score = 0;
          m_miss  = 0;
        end
      end
      1: begin
        if (e == CD_LEN - 1) begin
          m_state = 2;
          m_ps    = cyc + 1;
          m_req   = cyc + 1;
          m_clr   = cyc;
        end
      end
      default: begin
        tick = (e % T) == T - 1;
        // ticks seen since the ball timer was cleared, counting this cycle
        tmo  = tick && (((e + 1) / T) - ((m_clr - m_ps + 1) / T) == BT);
        acc  = h_e && !req_now;
        if (acc) m_score = (m_score >= 99) ? 99 : m_score + 1;
        else if (tmo) m_miss = (m_miss >= 99) ? 99 : m_miss + 1;
        if (acc || tmo) begin
          m_clr = cyc;
          if (e != PL_LEN - 1) m_req = cyc + 1;
        end
        if (e == PL_LEN - 1) begin
          m_state = 3;
          m_ps    = cyc + 1;
        end
      end
    endcase
    m_prev_s = s;
    m_prev_h = h;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_until(input int e_target);
    int n;
    n = 0;
    while ((cyc - m_ps) != e_target && n < 1000) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $error("FAIL idle_bound observed_phase_cycle=%0d expected=%0d", cyc - m_ps, e_target);
    end
  endtask

  initial begin
    bit h_cur;
    rst       = 1'b1;
    start_btn = 1'b0;
    hit       = 1'b0;
    req_seen  = 0;
    model_reset();

    apply_reset("reset_values");

    // Round 1: countdown timing, hits, held hit, hit on timeout, start ignored
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("cd_entry_state", state, 32'd1);
    chk("cd_entry_secs", seconds_left, 32'd3);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle_until(40);
    chk("cd_secs_2", seconds_left, 32'd2);
    idle_until(80);
    chk("cd_secs_1", seconds_left, 32'd1);
    idle_until(119);
    chk("cd_last_state", state, 32'd1);
    step(1'b0, 1'b0);
    chk("play_entry_state", state, 32'd2);
    chk("play_entry_secs", seconds_left, 32'd5);
    chk("play_entry_req", ball_req, 32'd1);
    chk("play_entry_visible", ball_visible, 32'd1);
    step(1'b0, 1'b0);
    chk("play_entry_req_one_cycle", ball_req, 32'd0);

    idle_until(5);
    step(1'b0, 1'b1);
    chk("hit1_req", ball_req, 32'd1);
    chk("hit1_score", score, 32'd1);
    idle_until(25);
    step(1'b0, 1'b1);
    chk("hit2_req", ball_req, 32'd1);
    chk("hit2_score", score, 32'd2);
    idle_until(45);
    step(1'b0, 1'b1);
    chk("hit3_req", ball_req, 32'd1);
    repeat (9) step(1'b0, 1'b1);
    chk("held_hit_score", score, 32'd3);
    chk("held_hit_misses", misses, 32'd0);

    idle_until(103);
    step(1'b0, 1'b1);
    chk("hit_on_timeout_score", score, 32'd4);
    chk("hit_on_timeout_misses", misses, 32'd0);
    chk("hit_on_timeout_req", ball_req, 32'd1);
    step(1'b0, 1'b0);
    chk("hit_on_timeout_single_req", ball_req, 32'd0);

    idle_until(150);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("start_in_play_ignored", state, 32'd2);
    idle_until(199);
    step(1'b0, 1'b0);
    chk("over_state", state, 32'd3);
    chk("over_game_over", game_over, 32'd1);
    chk("over_visible", ball_visible, 32'd0);
    chk("over_secs", seconds_left, 32'd0);
    chk("over_score", score, 32'd4);
    chk("over_misses", misses, 32'd1);
    repeat (5) step(1'b0, 1'b1);
    chk("over_score_held", score, 32'd4);

    // Round 2: restart from OVER, then a full round with no hits
    step(1'b1, 1'b0);
    chk("restart_state", state, 32'd1);
    chk("restart_score", score, 32'd0);
    idle_until(119);
    step(1'b0, 1'b0);
    req_seen = 0;
    idle_until(199);
    step(1'b0, 1'b0);
    chk("nohit_misses", misses, 32'd3);
    chk("nohit_req_count", req_seen, 32'd4);

    // Round 3: a hit edge every other cycle drives score into saturation
    step(1'b1, 1'b0);
    idle_until(119);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 105; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    chk("sat_state", state, 32'd3);
    chk("sat_score", score, 32'd99);

    // Randomized stretch: random hit toggling and occasional start presses
    h_cur = 1'b0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 2) == 0) h_cur = ~h_cur;
      step(($urandom_range(0, 59) == 0), h_cur);
    end

    // Asynchronous reset in the middle of PLAY
    apply_reset("reset_between");
    step(1'b1, 1'b0);
    idle_until(119);
    step(1'b0, 1'b0);
    idle_until(30);
    chk("pre_reset_playing", playing, 32'd1);
    apply_reset("reset_midplay");
    repeat (4) step(1'b0, 1'b0);
    chk("after_reset_state", state, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reflex_round_ctrl.md
# reflex_round_ctrl

Round sequencer for the reflex trainer. Turns the start trigger (right mouse button) and the mouse-on-ball hit indication into a timed round: countdown, play, game over. During play it paces ball spawns, counts hits and timed-out balls, and drives the seconds-remaining and score values shown on the seven-segment display. Sits between the mouse and hit-detect logic and the ball generator, display and seven-segment blocks.

## Interface
- TICK_CYCLES, 100000: clk cycles per internal tick (1 ms at 100 MHz).
- SEC_TICKS, 1000: ticks per second.
- COUNT_SEC, 3: countdown length in seconds (1..31).
- ROUND_SEC, 30: play length in seconds (1..31).
- BALL_TIMEOUT, 1500: ticks a ball stays up without a hit before it counts as a miss.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start_btn  in  1  start request, level, synchronous to clk; acted on at its rising edge.
- hit  in  1  cursor-on-ball-with-click, level; acted on at its rising edge.
- ball_req  out  1  one-cycle pulse asking the ball generator for a new position.
- ball_visible  out  1  ball is to be drawn.
- playing  out  1  high in PLAY.
- game_over  out  1  high in OVER.
- state  out  2  IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3.
- seconds_left  out  5  countdown or round seconds remaining.
- score  out  7  hits, saturating at 99.
- misses  out  7  timed-out balls, saturating at 99.

## Operation
- Edge detect: hit_d and start_d are registered copies of the inputs. hit_e = hit & ~hit_d; start_e = start_btn & ~start_d.
- Prescaler: tick_cnt runs 0..TICK_CYCLES-1. tick is high on the wrap cycle. sec_cnt counts ticks 0..SEC_TICKS-1, and sec is high when tick is high and sec_cnt wraps. Both counters clear on every state entry.
- IDLE: all outputs 0. start_e moves to COUNTDOWN.
- COUNTDOWN entry: seconds_left=COUNT_SEC; score and misses cleared. Each sec decrements seconds_left. A sec with seconds_left==1 moves to PLAY instead.
- PLAY entry: seconds_left=ROUND_SEC, ball_visible=1, ball_req pulses, ball timer cleared.
- PLAY behaviour:
  - ball timer increments on each tick.
  - hit_e: score+1 (saturating), ball_req pulse, ball timer cleared.
  - ball timer reaching BALL_TIMEOUT with no hit_e in that cycle: misses+1 (saturating), ball_req pulse, timer cleared.
  - hit_e and timeout in the same cycle: hit wins; no miss is counted.
  - hit_e in the same cycle that ball_req is high is ignored, because it belongs to the old ball.
  - sec decrements seconds_left. A sec with seconds_left==1 moves to OVER with seconds_left=0.
  - A hit_e in the expiry cycle is still scored, but no ball_req is issued.
- OVER: game_over=1, ball_visible=0, playing=0. score and misses are held. start_e moves to COUNTDOWN.
- start_e in COUNTDOWN or PLAY is ignored.
- hit_e outside PLAY is ignored.

## Timing
- All outputs are registered.
- Reset value of every output is 0, with state=IDLE. Internal counters and the edge registers also reset to 0.
- Reset asserted mid-round returns immediately (asynchronously) to IDLE with all outputs 0.
- The first start_btn after reset release is an edge only if start_d sampled 0.
- Input event in cycle k: state, score, misses and seconds_left update at the end of cycle k and are visible in k+1. ball_req is high in k+1 only.
- ball_req is never high on two consecutive cycles.
- COUNTDOWN lasts exactly COUNT_SEC·SEC_TICKS·TICK_CYCLES cycles. PLAY lasts exactly ROUND_SEC·SEC_TICKS·TICK_CYCLES cycles.
- Saturation: score/misses at 99 stay 99. No wrap.

## Test plan
Use TICK_CYCLES=4, SEC_TICKS=10, COUNT_SEC=3, ROUND_SEC=5, BALL_TIMEOUT=15 for all scenarios.

- Reset, then start_btn pulse → state=1 and seconds_left=3 one cycle later. seconds_left steps 3→2→1 every 40 cycles. After 120 cycles: state=2, seconds_left=5, ball_req high for one cycle, ball_visible=1.
- In PLAY, 3 hit pulses spaced 20 cycles apart → score=3 and misses=0. Each ball_req is exactly one cycle after its hit edge. A hit held high for 10 cycles counts once.
- In PLAY, no hits → a miss every 60 cycles (15 ticks). After 200 cycles of PLAY, misses=3 and ball_req has pulsed 4 times including the entry pulse.
- Hit edge in the same cycle as ball timeout → score+1, misses unchanged, single ball_req.
- Play runs out → after 200 cycles state=3, game_over=1, ball_visible=0, score held. start_btn pulse during PLAY has no effect. start_btn in OVER → COUNTDOWN with score=0.
- Force 105 hits with score saturating → score=99. rst low mid-PLAY → all outputs 0 in the same cycle, state=IDLE.
